hdlc_tx_ctrl: RTL and testbench
===============================

Name: hdlc_tx_ctrl

Overview:
Transmit-side frame sequencer for the HDLC core. It takes a frame of bytes already staged in the Tx buffer and produces the serial Tx line, in order: idle ones, start flag, data with zero-bit insertion, end flag. It also generates the abort pattern on request and drives the Tx status flags that the HDLC assertion bench monitors: Tx_ValidFrame and Tx_AbortedTrans.

Parameters:
MAX_BYTES, 126, maximum legal frame length in bytes.
SIZE_W, 8, width of Tx_FrameSize.

Ports:
Clk  in  1  system clock, all logic on rising edge.
Rst  in  1  reset, asynchronous, active-low.
Tx_Enable  in  1  frame start request, level, sampled only in IDLE.
Tx_FrameSize  in  SIZE_W  number of bytes in frame, sampled with Tx_Enable.
Tx_Data  in  8  byte from Tx buffer (first-word-fall-through), sampled on edge ending a Tx_RdBuff cycle.
Tx_AbortFrame  in  1  abort request, level.
Tx_RdBuff  out  1  one-cycle byte fetch strobe to Tx buffer.
Tx  out  1  serial line, registered, LSB of each byte first.
Tx_ValidFrame  out  1  high while flags/data of a frame are on Tx.
Tx_AbortedTrans  out  1  sticky abort status.
Tx_SizeErr  out  1  one-cycle pulse, start rejected.
Tx_Done  out  1  one-cycle pulse after last end-flag bit.

Behaviour:
- Reset values: Tx=1, Tx_ValidFrame=0, Tx_AbortedTrans=0, Tx_RdBuff=0, Tx_SizeErr=0, Tx_Done=0, state IDLE. Reset mid-frame returns Tx to 1 on the reset edge, with no flag or abort emitted.
- States: IDLE, SFLAG, DATA, EFLAG, ABORT.
- IDLE:
  - Tx=1.
  - Tx_Enable=1 with 1<=Tx_FrameSize<=MAX_BYTES: go to SFLAG, clear Tx_AbortedTrans, latch size.
  - Size 0 or >MAX_BYTES: pulse Tx_SizeErr next cycle and stay in IDLE.
- SFLAG: 8 cycles of Tx = 0,1,1,1,1,1,1,0. The first flag bit appears the cycle after acceptance.
- Tx_ValidFrame is high from the first SFLAG bit through the last EFLAG bit inclusive.
- Byte fetch:
  - Tx_RdBuff is high exactly in the cycle before bit 0 of each byte appears on Tx.
  - Tx_Data is loaded into the shift register on that edge.
  - First fetch coincides with the 8th start-flag bit.
  - Exactly FrameSize strobes per completed frame.
- DATA, zero insertion:
  - The ones counter resets at DATA entry and on any 0 on Tx, including a stuffed 0.
  - When 5 consecutive data 1s have been sent, the next Tx bit is a stuffed 0; the bit counter does not advance.
  - Runs span byte boundaries.
  - A run ending on bit 7 of the final byte gets its stuffed 0 before EFLAG.
  - The stuffed bit delays the next Tx_RdBuff by one cycle.
- EFLAG:
  - Same 8-bit flag pattern, no insertion.
  - Then Tx_Done pulses in the first IDLE cycle, with Tx_ValidFrame=0.
  - Back-to-back frames are not shared-flag: at least one IDLE cycle precedes the next SFLAG.
- Abort:
  - Tx_AbortFrame=1 in SFLAG/DATA/EFLAG: the next Tx bit starts the abort pattern 0,1,1,1,1,1,1,1 (8 cycles).
  - Tx_ValidFrame drops in the same cycle the first abort bit appears.
  - Tx_AbortedTrans is set that cycle and held until the next accepted start.
  - No further Tx_RdBuff is issued. ABORT then goes to IDLE; Tx_Done is not pulsed.
  - Tx_AbortFrame in IDLE or ABORT is ignored.
- Simultaneous events:
  - Tx_AbortFrame wins over a pending Tx_RdBuff or stuff bit in the same cycle.
  - In IDLE, Tx_Enable with an illegal size never raises Tx_ValidFrame.

Test Plan:
1. Size=1, Data=0x00: Tx = 01111110, 00000000, 01111110. Tx_ValidFrame 24 cycles, one Tx_RdBuff on the 8th SFLAG cycle, Tx_Done 1 cycle after.
2. Size=1, Data=0xFF: data bits 1,1,1,1,1,0(stuffed),1,1,1. Tx_ValidFrame 25 cycles. Tx never shows six consecutive 1s between flags.
3. Size=2, Data=0xF0,0x0F: Tx data = 0000 1111 1 0(stuffed) 111 0000. Second Tx_RdBuff on the last bit of byte 0. Total data 17 cycles.
4. Size=3 (0xAA,0x55,0xFF), Tx_AbortFrame pulsed during byte 1 bit 3: next bits 0,1111111, Tx_ValidFrame falls with the abort 0, Tx_AbortedTrans=1, only 2 Tx_RdBuff total. Following frame clears Tx_AbortedTrans.
5. Tx_Enable with Size=0, then Size=127: Tx_SizeErr pulses twice, Tx stays 1, no Tx_RdBuff, Tx_ValidFrame stays 0.
6. Rst low mid-DATA: Tx=1, all status 0 immediately. After release, a Size=1 frame transmits normally.

Source files
------------

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit frame sequencer.
// Serialises a staged frame as: idle ones, start flag, LSB-first data with
// zero-bit insertion, end flag. Also generates the abort sequence on request
// and reports frame validity, sticky abort, size error and completion.
module hdlc_tx_ctrl #(
  parameter int MAX_BYTES = 126,
  parameter int SIZE_W    = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tx_Enable,
  input  logic [SIZE_W-1:0] Tx_FrameSize,
  input  logic [7:0]        Tx_Data,
  input  logic              Tx_AbortFrame,
  output logic              Tx_RdBuff,
  output logic              Tx,
  output logic              Tx_ValidFrame,
  output logic              Tx_AbortedTrans,
  output logic              Tx_SizeErr,
  output logic              Tx_Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SFLAG = 3'd1,
    DATA  = 3'd2,
    EFLAG = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [7:0]        FLAG     = 8'b0111_1110;
  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_BYTES);
  localparam logic [SIZE_W-1:0] ONE_SIZE = SIZE_W'(1);

  // State describes the bit currently on Tx; cnt_r indexes the flag/abort
  // bit or the data bit on the line (it holds during a stuffed zero).
  state_t            state_r;
  logic [2:0]        cnt_r;
  logic [7:0]        data_r;
  logic [2:0]        ones_r;   // consecutive data ones ending with the bit on Tx
  logic [SIZE_W-1:0] left_r;   // bytes of the frame not yet fetched

  logic [2:0] next_bit_s;
  logic       next_data_s;
  logic       next_flag_s;
  logic [2:0] ones_inc_s;
  logic [2:0] ones_load_s;
  logic       size_ok_s;
  logic       in_frame_s;

  // Next-bit helpers shared by the sequencer.
  always_comb begin
    next_bit_s  = cnt_r + 3'd1;
    next_data_s = data_r[next_bit_s];
    next_flag_s = FLAG[next_bit_s];
    ones_inc_s  = next_data_s ? (ones_r + 3'd1) : 3'd0;
    ones_load_s = Tx_Data[0] ? (ones_r + 3'd1) : 3'd0;
    size_ok_s   = (Tx_FrameSize != {SIZE_W{1'b0}}) && (Tx_FrameSize <= MAX_SIZE);
    in_frame_s  = (state_r == SFLAG) || (state_r == DATA) || (state_r == EFLAG);
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r         <= IDLE;
      cnt_r           <= 3'd0;
      data_r          <= 8'd0;
      ones_r          <= 3'd0;
      left_r          <= {SIZE_W{1'b0}};
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_RdBuff       <= 1'b0;
      Tx_SizeErr      <= 1'b0;
      Tx_Done         <= 1'b0;
    end else begin
      Tx_RdBuff  <= 1'b0;
      Tx_SizeErr <= 1'b0;
      Tx_Done    <= 1'b0;
      if (in_frame_s && Tx_AbortFrame) begin
        // Abort overrides any pending fetch or stuffed zero.
        state_r         <= ABORT;
        cnt_r           <= 3'd0;
        Tx              <= 1'b0;
        Tx_ValidFrame   <= 1'b0;
        Tx_AbortedTrans <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            Tx            <= 1'b1;
            Tx_ValidFrame <= 1'b0;
            if (Tx_Enable) begin
              if (size_ok_s) begin
                state_r         <= SFLAG;
                cnt_r           <= 3'd0;
                Tx              <= FLAG[0];
                Tx_ValidFrame   <= 1'b1;
                Tx_AbortedTrans <= 1'b0;
                left_r          <= Tx_FrameSize;
              end else begin
                Tx_SizeErr <= 1'b1;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          SFLAG: begin
            if (cnt_r != 3'd7) begin
              cnt_r     <= next_bit_s;
              Tx        <= next_flag_s;
              Tx_RdBuff <= (next_bit_s == 3'd7);
            end else begin
              state_r <= DATA;
              cnt_r   <= 3'd0;
              data_r  <= Tx_Data;
              Tx      <= Tx_Data[0];
              ones_r  <= Tx_Data[0] ? 3'd1 : 3'd0;
              left_r  <= left_r - ONE_SIZE;
            end
          end
          DATA: begin
            if (ones_r == 3'd5) begin
              // Stuffed zero: bit index holds, fetch slips by one cycle.
              Tx        <= 1'b0;
              ones_r    <= 3'd0;
              Tx_RdBuff <= (cnt_r == 3'd7) && (left_r != {SIZE_W{1'b0}});
            end else if (cnt_r != 3'd7) begin
              cnt_r     <= next_bit_s;
              Tx        <= next_data_s;
              ones_r    <= ones_inc_s;
              Tx_RdBuff <= (next_bit_s == 3'd7) && (left_r != {SIZE_W{1'b0}}) &&
                           (ones_inc_s != 3'd5);
            end else if (left_r != {SIZE_W{1'b0}}) begin
              cnt_r  <= 3'd0;
              data_r <= Tx_Data;
              Tx     <= Tx_Data[0];
              ones_r <= ones_load_s;
              left_r <= left_r - ONE_SIZE;
            end else begin
              state_r <= EFLAG;
              cnt_r   <= 3'd0;
              Tx      <= FLAG[0];
            end
          end
          EFLAG: begin
            if (cnt_r != 3'd7) begin
              cnt_r <= next_bit_s;
              Tx    <= next_flag_s;
            end else begin
              state_r       <= IDLE;
              Tx            <= 1'b1;
              Tx_ValidFrame <= 1'b0;
              Tx_Done       <= 1'b1;
            end
          end
          ABORT: begin
            if (cnt_r != 3'd7) begin
              cnt_r <= next_bit_s;
              Tx    <= 1'b1;
            end else begin
              state_r <= IDLE;
              Tx      <= 1'b1;
            end
          end
          default: begin
            state_r       <= IDLE;
            Tx            <= 1'b1;
            Tx_ValidFrame <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// Self-checking bench for hdlc_tx_ctrl: a frame-level reference model builds
// the whole expected line sequence when a frame is accepted, and a single
// compare process checks every DUT output on every falling clock edge.
module tb_hdlc_tx_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_Enable;
  logic [7:0] Tx_FrameSize;
  logic [7:0] Tx_Data;
  logic       Tx_AbortFrame;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_SizeErr;
  logic       Tx_Done;

  hdlc_tx_ctrl #(.MAX_BYTES(126), .SIZE_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_FrameSize(Tx_FrameSize),
    .Tx_Data(Tx_Data), .Tx_AbortFrame(Tx_AbortFrame), .Tx_RdBuff(Tx_RdBuff),
    .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame), .Tx_AbortedTrans(Tx_AbortedTrans),
    .Tx_SizeErr(Tx_SizeErr), .Tx_Done(Tx_Done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- Tx buffer (first-word-fall-through) ----------------
  logic [7:0] feed_mem [256];
  logic [7:0] feed_rd = 8'd0;
  assign Tx_Data = feed_mem[feed_rd];

  initial begin
    forever begin
      @(posedge Clk);
      if (Rst && Tx_RdBuff) feed_rd <= feed_rd + 8'd1;
    end
  end

  task automatic set_byte(input int j, input logic [7:0] v);
    logic [7:0] idx;
    idx = feed_rd + j[7:0];
    feed_mem[idx] = v;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic tx; logic valid; logic rd; logic done; logic serr; logic ab; logic idle;
  } ent_t;

  ent_t q[$];
  ent_t cur;

  function automatic ent_t mk(input logic tx, input logic valid, input logic rd,
                              input logic done, input logic serr, input logic ab,
                              input logic idle);
    ent_t e;
    e.tx = tx; e.valid = valid; e.rd = rd; e.done = done;
    e.serr = serr; e.ab = ab; e.idle = idle;
    return e;
  endfunction

  // Line bit stream of a whole frame: flag, stuffed data, flag.
  // f marks positions where a byte's bit 0 appears.
  function automatic void build_stream(input int n, input logic [7:0] b [128],
                                       output logic [2047:0] s, output logic [2047:0] f,
                                       output int len);
    logic [7:0] flg;
    int ones;
    logic v;
    flg = 8'h7E;
    s = '0; f = '0; len = 0; ones = 0;
    for (int k = 0; k < 8; k++) begin s[len] = flg[k]; len++; end
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < 8; i++) begin
        v = b[j][i];
        if (i == 0) f[len] = 1'b1;
        s[len] = v; len++;
        ones = v ? ones + 1 : 0;
        if (ones == 5) begin s[len] = 1'b0; len++; ones = 0; end
      end
    end
    for (int k = 0; k < 8; k++) begin s[len] = flg[k]; len++; end
  endfunction

  task automatic model_frame(input int n);
    logic [7:0] b [128];
    logic [2047:0] s, f;
    int len;
    logic [7:0] idx;
    for (int j = 0; j < 128; j++) begin
      idx = feed_rd + j[7:0];
      b[j] = feed_mem[idx];
    end
    build_stream(n, b, s, f, len);
    for (int i = 0; i < len; i++)
      q.push_back(mk(s[i], 1'b1, (i + 1 < len) ? f[i+1] : 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    forever begin
      @(posedge Clk);
      if (!Rst) begin
        q.delete();
        cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        if (cur.idle && Tx_Enable) begin
          if (Tx_FrameSize >= 8'd1 && Tx_FrameSize <= 8'd126) model_frame(int'(Tx_FrameSize));
          else q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cur.ab, 1'b1));
        end else if (cur.valid && Tx_AbortFrame) begin
          q.delete();
          q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
          for (int k = 0; k < 7; k++) q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur.ab, 1'b1);
      end
    end
  end

  // ---------------- compare process ----------------
  int n_valid = 0, n_rd = 0, n_done = 0, n_serr = 0;

  initial begin
    forever begin
      @(negedge Clk);
      check("tx",      Tx,              cur.tx);
      check("valid",   Tx_ValidFrame,   cur.valid);
      check("rdbuff",  Tx_RdBuff,       cur.rd);
      check("done",    Tx_Done,         cur.done);
      check("sizeerr", Tx_SizeErr,      cur.serr);
      check("aborted", Tx_AbortedTrans, cur.ab);
      if (Tx_ValidFrame) n_valid++;
      if (Tx_RdBuff)     n_rd++;
      if (Tx_Done)       n_done++;
      if (Tx_SizeErr)    n_serr++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int s_valid, s_rd, s_done, s_serr;

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge Clk); #1;
      if (cur.idle && q.size() == 0 && !cur.done && !cur.serr) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Drive a one-cycle start request after snapshotting the output counters.
  task automatic start(input logic [7:0] size);
    s_valid = n_valid; s_rd = n_rd; s_done = n_done; s_serr = n_serr;
    Tx_FrameSize = size;
    Tx_Enable = 1'b1;
    @(negedge Clk); #1;
    Tx_Enable = 1'b0;
  endtask

  task automatic frame_counts(input string name, input int ev, input int er, input int ed);
    check({name, "_valid_cycles"}, n_valid - s_valid, ev);
    check({name, "_rd_count"},     n_rd - s_rd,       er);
    check({name, "_done_count"},   n_done - s_done,   ed);
  endtask

  // Frame with an abort request raised during frame cycle acyc (1 = first flag bit).
  task automatic abort_run(input string name, input logic [7:0] size, input int acyc, input int er);
    start(size);
    repeat (acyc - 1) @(negedge Clk);
    #1 Tx_AbortFrame = 1'b1;
    @(negedge Clk); #1 Tx_AbortFrame = 1'b0;
    wait_idle(200);
    frame_counts(name, acyc, er, 0);
    check({name, "_aborted_sticky"}, Tx_AbortedTrans, 1'b1);
  endtask

  task automatic pin_model;
    logic [7:0] b [128];
    logic [2047:0] s, f;
    logic [16:0] d17;
    logic [8:0] d9;
    logic [7:0] fl;
    int len;
    for (int j = 0; j < 128; j++) b[j] = 8'h00;
    build_stream(1, b, s, f, len);
    check("pin_len_00", len, 24);
    b[0] = 8'hFF;
    build_stream(1, b, s, f, len);
    d9 = s[16:8];
    check("pin_len_ff", len, 25);
    check("pin_bits_ff", d9, 9'b111_0_11111);
    b[0] = 8'hF0; b[1] = 8'h0F;
    build_stream(2, b, s, f, len);
    d17 = s[24:8];
    check("pin_len_f00f", len, 33);
    check("pin_bits_f00f", d17, 17'b0000_111_0_11111_0000);
    d17 = f[24:8];
    check("pin_starts_f00f", d17, 17'h00101);
    fl = s[32:25];
    check("pin_eflag", fl, 8'h7E);
  endtask

  function automatic logic [7:0] rnd_byte;
    case ($urandom_range(0, 4))
      0: return 8'hFF;
      1: return 8'h7E;
      2: return 8'h1F;
      3: return 8'hF8;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) feed_mem[i] = 8'h00;
    Rst = 1'b0; Tx_Enable = 1'b0; Tx_FrameSize = 8'd0; Tx_AbortFrame = 1'b0;
    pin_model();
    repeat (3) @(negedge Clk);
    #1;
    check("reset_tx", Tx, 1'b1);
    check("reset_valid", Tx_ValidFrame, 1'b0);
    Rst = 1'b1;
    wait_idle(10);

    // Single zero byte.
    set_byte(0, 8'h00); start(8'd1); wait_idle(100);
    frame_counts("t1", 24, 1, 1);

    // All ones: one stuffed zero.
    set_byte(0, 8'hFF); start(8'd1); wait_idle(100);
    frame_counts("t2", 25, 1, 1);

    // Run spanning a byte boundary.
    set_byte(0, 8'hF0); set_byte(1, 8'h0F); start(8'd2); wait_idle(100);
    frame_counts("t3", 33, 2, 1);

    // Abort during byte 1 bit 3, then a clean frame clears the sticky flag.
    set_byte(0, 8'hAA); set_byte(1, 8'h55); set_byte(2, 8'hFF);
    abort_run("t4", 8'd3, 20, 2);
    set_byte(0, 8'h00); start(8'd1);
    check("t4_aborted_cleared", Tx_AbortedTrans, 1'b0);
    wait_idle(100);
    frame_counts("t4b", 24, 1, 1);

    // Abort before the first fetch, and abort competing with a stuffed zero.
    set_byte(0, 8'h3C); set_byte(1, 8'h3C); abort_run("ab_prefetch", 8'd2, 7, 0);
    set_byte(0, 8'hFF); set_byte(1, 8'hFF); abort_run("ab_stuff", 8'd2, 13, 1);

    // Abort in IDLE is ignored.
    Tx_AbortFrame = 1'b1; repeat (3) @(negedge Clk); #1 Tx_AbortFrame = 1'b0;

    // Illegal sizes.
    s_valid = n_valid; s_rd = n_rd; s_serr = n_serr;
    Tx_FrameSize = 8'd0; Tx_Enable = 1'b1; @(negedge Clk); #1 Tx_Enable = 1'b0;
    @(negedge Clk); #1;
    Tx_FrameSize = 8'd127; Tx_Enable = 1'b1; @(negedge Clk); #1 Tx_Enable = 1'b0;
    wait_idle(20);
    check("t5_sizeerr_count", n_serr - s_serr, 2);
    check("t5_rd_count", n_rd - s_rd, 0);
    check("t5_valid_cycles", n_valid - s_valid, 0);

    // Maximum length frame.
    for (int j = 0; j < 126; j++) set_byte(j, rnd_byte());
    start(8'd126); wait_idle(2000);
    check("max_rd_count", n_rd - s_rd, 126);
    check("max_done_count", n_done - s_done, 1);

    // Reset in the middle of DATA.
    for (int j = 0; j < 4; j++) set_byte(j, 8'($urandom_range(0, 255)));
    start(8'd4);
    repeat (12) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("t6_tx", Tx, 1'b1);
    check("t6_valid", Tx_ValidFrame, 1'b0);
    check("t6_rd", Tx_RdBuff, 1'b0);
    check("t6_aborted", Tx_AbortedTrans, 1'b0);
    check("t6_done", Tx_Done, 1'b0);
    repeat (2) @(negedge Clk);
    #1 Rst = 1'b1;
    @(negedge Clk); #1;
    set_byte(0, 8'h00); start(8'd1); wait_idle(100);
    frame_counts("t6b", 24, 1, 1);

    // Randomized traffic with random aborts, illegal sizes and back-to-back starts.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk); #1;
      if (cur.idle && q.size() == 0)
        for (int j = 0; j < 10; j++) set_byte(j, rnd_byte());
      Tx_Enable = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)
        Tx_FrameSize = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(127, 255));
      else
        Tx_FrameSize = 8'($urandom_range(1, 10));
      Tx_AbortFrame = ($urandom_range(0, 59) == 0);
    end
    Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0;
    wait_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
